// File: rtl/datapath_ctrl.sv
// datapath_ctrl: fetch/decode/sequence unit for the 4-bit register/ALU datapath.
// Fetches 8-bit instructions from a synchronous ROM (one-cycle read latency),
// decodes them into datapath control strobes and handles jmp / jz / halt.
// Every instruction takes FETCH -> WAIT -> EXEC (3 cycles).
module datapath_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        imem_rdata,
    input  logic [3:0]        R0,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    output logic [1:0]        SEL_A,
    output logic [1:0]        SEL_B,
    output logic [1:0]        SEL_W,
    output logic [3:0]        IMM,
    output logic              sel_data,
    output logic              write_en,
    output logic              alu_op,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [7:0] IR_NOOP = 8'hC0;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [7:0]          r_ir;
    logic [7:0]          r_retired;

    logic [1:0]          w_op;
    logic [1:0]          w_sub;
    logic                w_is_write;
    logic                w_is_halt;
    logic                w_is_jmp;
    logic                w_is_jz;
    logic                w_take;
    logic                w_start_ok;
    logic [ADDR_W-1:0]   w_tgt;

    // Instruction field split and flow-control decode.
    assign w_op       = r_ir[7:6];
    assign w_sub      = r_ir[5:4];
    assign w_is_write = (w_op != 2'b11);
    assign w_is_halt  = (w_op == 2'b11) && (w_sub == 2'b01);
    assign w_is_jmp   = (w_op == 2'b11) && (w_sub == 2'b10);
    assign w_is_jz    = (w_op == 2'b11) && (w_sub == 2'b11);
    // R0 is sampled live during EXEC, so a write landing on the same edge is not seen.
    assign w_take     = w_is_jmp || (w_is_jz && (R0 == 4'b0000));
    assign w_tgt      = ADDR_W'(r_ir[3:0]);
    // start only restarts an idle or halted machine; mid-instruction it is dropped.
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_HALT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  w_next = S_EXEC;
            S_EXEC:  w_next = w_is_halt ? S_HALT : S_FETCH;
            S_HALT:  if (start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // State-dependent strobes; writes only happen for push/add/nand in EXEC.
    always_comb begin
        imem_rd  = 1'b0;
        write_en = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_rd = 1'b1;
                busy    = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            S_EXEC: begin
                busy     = 1'b1;
                write_en = w_is_write;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath selects decode straight from IR regardless of state.
    always_comb begin
        SEL_A    = 2'b00;
        SEL_B    = 2'b00;
        SEL_W    = 2'b00;
        IMM      = r_ir[3:0];
        sel_data = 1'b0;
        alu_op   = 1'b0;
        case (w_op)
            2'b00: begin
                sel_data = 1'b1;
                SEL_W    = r_ir[5:4];
            end
            2'b01, 2'b10: begin
                SEL_W  = r_ir[5:4];
                SEL_A  = r_ir[3:2];
                SEL_B  = r_ir[1:0];
                alu_op = w_op[1];
            end
            default: ;
        endcase
    end

    // Program counter: cleared on start, advanced or redirected at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (w_start_ok) begin
            r_pc <= '0;
        end else if (r_state == S_EXEC) begin
            r_pc <= w_take ? w_tgt : r_pc + ADDR_W'(1);
        end
    end

    // Instruction register: captures the ROM word that arrives during WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_ir <= IR_NOOP;
        else if (r_state == S_WAIT) r_ir <= imem_rdata;
    end

    // Retired-instruction counter, saturating at 255, cleared on each start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= 8'd0;
        end else if (w_start_ok) begin
            r_retired <= 8'd0;
        end else if ((r_state == S_EXEC) && (r_retired != 8'hFF)) begin
            r_retired <= r_retired + 8'd1;
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign retired   = r_retired;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: behavioural sync ROM, write-strobe scoreboard,
// and one task per scenario checking timing, flow control and boundaries.
module tb_datapath_ctrl;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        imem_rdata;
    logic [3:0]        R0 = 4'd0;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [1:0]        SEL_A, SEL_B, SEL_W;
    logic [3:0]        IMM;
    logic              sel_data, write_en, alu_op;
    logic [ADDR_W-1:0] pc;
    logic              busy, halted;
    logic [7:0]        retired;

    datapath_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_rdata(imem_rdata), .R0(R0),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .SEL_A(SEL_A), .SEL_B(SEL_B),
        .SEL_W(SEL_W), .IMM(IMM), .sel_data(sel_data), .write_en(write_en),
        .alu_op(alu_op), .pc(pc), .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: data valid the cycle after imem_rd.
    logic [7:0] mem [16];
    always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

    typedef struct {
        logic [1:0] w, a, b;
        logic [3:0] imm;
        logic       sd, op;
        bit         chk_imm;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic exp_wr(input logic [1:0] w, a, b, input logic [3:0] imm,
                          input logic sd, op, input bit chk_imm);
        wr_t e;
        e.w = w; e.a = a; e.b = b; e.imm = imm; e.sd = sd; e.op = op; e.chk_imm = chk_imm;
        exp_q.push_back(e);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    // Advance one cycle, sample at the falling edge, score any datapath write.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        @(negedge clk);
        if (write_en === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: write_en=1 pc=%0d SEL_W=%0d, required no write", pc, SEL_W);
            end else begin
                e = exp_q.pop_front();
                if ({SEL_W, SEL_A, SEL_B, sel_data, alu_op} !== {e.w, e.a, e.b, e.sd, e.op} ||
                    (e.chk_imm && IMM !== e.imm)) begin
                    n_err++;
                    $display("FAIL write_fields: got W=%0d A=%0d B=%0d IMM=%h sd=%b op=%b, required W=%0d A=%0d B=%0d IMM=%h sd=%b op=%b",
                             SEL_W, SEL_A, SEL_B, IMM, sel_data, alu_op, e.w, e.a, e.b, e.imm, e.sd, e.op);
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        int k = 0;
        while (halted !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, budget);
        end
    endtask

    task automatic check_drained(input string tag);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_writes: %0d pending, required 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({imem_addr, imem_rd, SEL_A, SEL_B, SEL_W, IMM, sel_data, write_en, alu_op,
             pc, busy, halted, retired} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: pc=%0d rd=%b we=%b busy=%b halted=%b ret=%0d IMM=%h, required all 0",
                     pc, imem_rd, write_en, busy, halted, retired, IMM);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_vec++;
            if (imem_rd !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || pc !== 4'd0) begin
                n_err++;
                $display("FAIL idle_cycle%0d: rd=%b busy=%b halted=%b pc=%0d, required 0 0 0 0",
                         c, imem_rd, busy, halted, pc);
            end
        end
    endtask

    task automatic test_linear();
        fill(8'hC0);
        mem[0] = 8'h00; mem[1] = 8'h1F; mem[2] = 8'h64; mem[3] = 8'hD0;
        exp_wr(2'd0, 2'd0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1);
        exp_wr(2'd1, 2'd0, 2'd0, 4'hF, 1'b1, 1'b0, 1'b1);
        exp_wr(2'd2, 2'd1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            n_vec++;
            if (write_en !== ((c % 3 == 0) && (c <= 9))) begin
                n_err++;
                $display("FAIL linear_we_cycle%0d: write_en=%b, required %b", c, write_en,
                         (c % 3 == 0) && (c <= 9));
            end
        end
        tick();
        n_vec++;
        if (halted !== 1'b1 || pc !== 4'd4 || retired !== 8'd4 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL linear_end: halted=%b pc=%0d retired=%0d busy=%b, required 1 4 4 0",
                     halted, pc, retired, busy);
        end
        check_drained("linear");
    endtask

    task automatic test_nand();
        fill(8'hC0);
        mem[0] = 8'hB7; mem[1] = 8'hD0;
        exp_wr(2'd3, 2'd1, 2'd3, 4'h7, 1'b0, 1'b1, 1'b0);
        pulse_start();
        tick();
        tick();
        n_vec++;
        if (write_en !== 1'b1 || alu_op !== 1'b1) begin
            n_err++;
            $display("FAIL nand_exec: write_en=%b alu_op=%b, required 1 1", write_en, alu_op);
        end
        run_to_halt(20);
        n_vec++;
        if (pc !== 4'd2 || retired !== 8'd2) begin
            n_err++;
            $display("FAIL nand_end: pc=%0d retired=%0d, required 2 2", pc, retired);
        end
        check_drained("nand");
    endtask

    // One flow instruction at address 0; the wrong-path slot holds a push so a
    // mispredicted branch shows up as an unexpected write.
    task automatic flow_case(input string tag, input logic [7:0] ins, input logic [3:0] r0v,
                             input logic [3:0] npc, input logic [3:0] other);
        fill(8'hC0);
        mem[0] = ins; mem[other] = 8'h01; mem[npc] = 8'hD0;
        R0 = r0v;
        pulse_start();
        tick();
        tick();
        n_vec++;
        if (write_en !== 1'b0) begin
            n_err++;
            $display("FAIL %s_we: write_en=%b, required 0", tag, write_en);
        end
        tick();
        n_vec++;
        if (pc !== npc || imem_addr !== npc || imem_rd !== 1'b1) begin
            n_err++;
            $display("FAIL %s_target: pc=%0d addr=%0d rd=%b, required pc=addr=%0d rd=1",
                     tag, pc, imem_addr, imem_rd, npc);
        end
        run_to_halt(20);
        n_vec++;
        if (pc !== npc + 4'd1 || retired !== 8'd2) begin
            n_err++;
            $display("FAIL %s_end: pc=%0d retired=%0d, required %0d 2", tag, pc, retired, npc + 4'd1);
        end
        check_drained(tag);
    endtask

    task automatic test_flow();
        flow_case("jz_taken", 8'hF5, 4'b0000, 4'd5, 4'd1);
        flow_case("jz_not",   8'hF5, 4'b0010, 4'd1, 4'd5);
        flow_case("jmp",      8'hE2, 4'b0010, 4'd2, 4'd1);
        // jz to itself spins while R0 == 0, falls through once R0 changes.
        fill(8'hC0);
        mem[0] = 8'hF0; mem[1] = 8'hD0;
        R0 = 4'd0;
        pulse_start();
        repeat (6) tick();
        n_vec++;
        if (pc !== 4'd0 || retired !== 8'd2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL spin_loop: pc=%0d retired=%0d busy=%b, required 0 2 1", pc, retired, busy);
        end
        R0 = 4'd2;
        run_to_halt(20);
        n_vec++;
        if (pc !== 4'd2 || retired !== 8'd4) begin
            n_err++;
            $display("FAIL spin_exit: pc=%0d retired=%0d, required 2 4", pc, retired);
        end
        check_drained("spin");
    endtask

    task automatic test_wrap();
        int cyc;
        fill(8'hC0);
        R0 = 4'd1;
        pulse_start();
        cyc = 1;
        while (cyc < 46) begin tick(); cyc++; end
        n_vec++;
        if (pc !== 4'd15 || retired !== 8'd15) begin
            n_err++;
            $display("FAIL wrap_pc15: pc=%0d retired=%0d, required 15 15", pc, retired);
        end
        while (cyc < 49) begin tick(); cyc++; end
        n_vec++;
        if (imem_addr !== 4'd0 || imem_rd !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_fetch0: addr=%0d rd=%b, required 0 1", imem_addr, imem_rd);
        end
        while (cyc < 763) begin tick(); cyc++; end
        n_vec++;
        if (retired !== 8'd254) begin
            n_err++;
            $display("FAIL retired_254: retired=%0d, required 254", retired);
        end
        while (cyc < 901) begin tick(); cyc++; end
        n_vec++;
        if (retired !== 8'd255) begin
            n_err++;
            $display("FAIL retired_sat: retired=%0d, required 255", retired);
        end
        fill(8'hD0);
        run_to_halt(10);
        n_vec++;
        if (retired !== 8'd255) begin
            n_err++;
            $display("FAIL retired_sat_halt: retired=%0d, required 255", retired);
        end
        check_drained("wrap");
    endtask

    task automatic test_reset_mid();
        fill(8'hC0);
        mem[0] = 8'h00;
        exp_wr(2'd0, 2'd0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1);
        pulse_start();
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (write_en !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: we=%b pc=%0d busy=%b halted=%b, required 0 0 0 0",
                     write_en, pc, busy, halted);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0 || imem_rd !== 1'b0 || pc !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_idle: busy=%b rd=%b pc=%0d, required 0 0 0", busy, imem_rd, pc);
        end
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back();
        fill(8'hC0);
        mem[0] = 8'hD0;
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        tick();
        n_vec++;
        if (halted !== 1'b1 || pc !== 4'd1 || retired !== 8'd1) begin
            n_err++;
            $display("FAIL start_ignored: halted=%b pc=%0d retired=%0d, required 1 1 1", halted, pc, retired);
        end
        mem[0] = 8'h25; mem[1] = 8'hD0;
        exp_wr(2'd2, 2'd0, 2'd0, 4'h5, 1'b1, 1'b0, 1'b1);
        pulse_start();
        n_vec++;
        if (busy !== 1'b1 || halted !== 1'b0 || pc !== 4'd0 || imem_rd !== 1'b1 || retired !== 8'd0) begin
            n_err++;
            $display("FAIL halt_restart: busy=%b halted=%b pc=%0d rd=%b retired=%0d, required 1 0 0 1 0",
                     busy, halted, pc, imem_rd, retired);
        end
        run_to_halt(20);
        n_vec++;
        if (pc !== 4'd2 || retired !== 8'd2) begin
            n_err++;
            $display("FAIL restart_end: pc=%0d retired=%0d, required 2 2", pc, retired);
        end
        check_drained("restart");
    endtask

    initial begin
        test_reset();
        test_linear();
        test_nand();
        test_flow();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
